// File: rtl/data_mem_responder.sv
// Handshake-based data memory: accepts one load/store, waits LATENCY cycles,
// then commits the store or returns extended load data, with error flagging.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  input  logic [2:0]  reqFunct3,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respReadData,
  output logic        respError
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t        state_r, nextState_s;
  logic [CW-1:0] count_r;
  logic          capWrite_r;
  logic [31:0]   capAddress_r, capWriteData_r;
  logic [2:0]    capFunct3_r;
  logic [31:0]   respReadData_r;
  logic          respError_r;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept_s, access_s, curWrite_s, curError_s;
  logic [31:0]   curAddress_s, curWriteData_s, rdWord_s;
  logic [2:0]    curFunct3_s;
  logic [AW-1:0] curIdx_s;
  logic [3:0]    byteEn_s;
  logic [31:0]   laneData_s;

  function automatic logic reqIllegal(input logic write, input logic [31:0] addr,
                                      input logic [2:0] f3);
    logic bad;
    case (f3)
      3'd0:    bad = 1'b0;
      3'd1:    bad = addr[0];
      3'd2:    bad = (addr[1:0] != 2'b00);
      3'd4:    bad = write;
      3'd5:    bad = write | addr[0];
      default: bad = 1'b1;
    endcase
    return bad | (|addr[31:AW+2]);
  endfunction

  function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [2:0] f3);
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] result;
    shifted = word >> {lane, 3'b000};
    half    = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    result = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    result = {{16{half[15]}}, half};
      3'd2:    result = word;
      3'd4:    result = {24'd0, shifted[7:0]};
      3'd5:    result = {16'd0, half};
      default: result = 32'd0;
    endcase
    return result;
  endfunction

  // With LATENCY=1 the access happens on the accept edge, so it must see live inputs.
  always_comb begin
    accept_s = (state_r == IDLE) && reqValid;
    access_s = 1'b0;
    if (state_r == IDLE) begin
      curWrite_s     = reqWrite;
      curAddress_s   = reqAddress;
      curWriteData_s = reqWriteData;
      curFunct3_s    = reqFunct3;
      access_s       = accept_s && (LATENCY == 1);
    end else begin
      curWrite_s     = capWrite_r;
      curAddress_s   = capAddress_r;
      curWriteData_s = capWriteData_r;
      curFunct3_s    = capFunct3_r;
      access_s       = (state_r == BUSY) && (count_r == CW'(1));
    end
    curError_s = reqIllegal(curWrite_s, curAddress_s, curFunct3_s);
    curIdx_s   = curAddress_s[AW+1:2];
    rdWord_s   = mem[curIdx_s];
  end

  // Byte-enable and lane-replicated store data.
  always_comb begin
    case (curFunct3_s)
      3'd0: begin
        byteEn_s   = 4'b0001 << curAddress_s[1:0];
        laneData_s = {4{curWriteData_s[7:0]}};
      end
      3'd1: begin
        byteEn_s   = curAddress_s[1] ? 4'b1100 : 4'b0011;
        laneData_s = {2{curWriteData_s[15:0]}};
      end
      3'd2: begin
        byteEn_s   = 4'b1111;
        laneData_s = curWriteData_s;
      end
      default: begin
        byteEn_s   = 4'b0000;
        laneData_s = 32'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= nextState_s;
  end

  // Next-state logic.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (reqValid) nextState_s = (LATENCY == 1) ? RESP : BUSY;
        else          nextState_s = IDLE;
      end
      BUSY: begin
        if (count_r == CW'(1)) nextState_s = RESP;
        else                   nextState_s = BUSY;
      end
      RESP: begin
        if (respReady) nextState_s = IDLE;
        else           nextState_s = RESP;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    case (state_r)
      IDLE:    begin reqReady = 1'b1; respValid = 1'b0; end
      BUSY:    begin reqReady = 1'b0; respValid = 1'b0; end
      RESP:    begin reqReady = 1'b0; respValid = 1'b1; end
      default: begin reqReady = 1'b0; respValid = 1'b0; end
    endcase
    respReadData = respReadData_r;
    respError    = respError_r;
  end

  // Request capture, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r        <= CW'(0);
      capWrite_r     <= 1'b0;
      capAddress_r   <= 32'd0;
      capWriteData_r <= 32'd0;
      capFunct3_r    <= 3'd0;
      respReadData_r <= 32'd0;
      respError_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        capWrite_r     <= reqWrite;
        capAddress_r   <= reqAddress;
        capWriteData_r <= reqWriteData;
        capFunct3_r    <= reqFunct3;
        count_r        <= CW'(LATENCY - 1);
      end else if (state_r == BUSY) begin
        count_r <= count_r - CW'(1);
      end else begin
        count_r <= count_r;
      end
      if (access_s) begin
        respError_r    <= curError_s;
        respReadData_r <= (curError_s || curWrite_s) ? 32'd0
                          : loadExtend(rdWord_s, curAddress_s[1:0], curFunct3_s);
      end else begin
        respError_r    <= respError_r;
        respReadData_r <= respReadData_r;
      end
    end
  end

  // Storage has no reset; a reset on the access edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (access_s && !reset && curWrite_s && !curError_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn_s[i]) mem[curIdx_s][8*i +: 8] <= laneData_s[8*i +: 8];
      end
    end
  end

endmodule
